// File: rtl/lcd_4bit_responder_pkg.sv
// rtl/lcd_4bit_responder_pkg.sv - shared constants and decode helpers for the HD44780-style responder
package lcd_4bit_responder_pkg;

    localparam int AC_W           = 7;
    localparam int BUSY_CNT_W     = 18;
    localparam int BUSY_SHORT_DEF = 4000;
    localparam int BUSY_LONG_DEF  = 152000;

    // Instruction opcodes are identified by a leading-ones prefix: mask selects the prefix bits.
    localparam logic [7:0] OP_CLEAR_MASK = 8'hFF, OP_CLEAR_VAL = 8'h01;
    localparam logic [7:0] OP_HOME_MASK  = 8'hFE, OP_HOME_VAL  = 8'h02;
    localparam logic [7:0] OP_ENTRY_MASK = 8'hFC, OP_ENTRY_VAL = 8'h04;
    localparam logic [7:0] OP_DISP_MASK  = 8'hF8, OP_DISP_VAL  = 8'h08;
    localparam logic [7:0] OP_SHIFT_MASK = 8'hF0, OP_SHIFT_VAL = 8'h10;
    localparam logic [7:0] OP_FUNC_MASK  = 8'hE0, OP_FUNC_VAL  = 8'h20;
    localparam logic [7:0] OP_CGRAM_MASK = 8'hC0, OP_CGRAM_VAL = 8'h40;
    localparam logic [7:0] OP_DDRAM_MASK = 8'h80, OP_DDRAM_VAL = 8'h80;

    function automatic logic op_match(input logic [7:0] b, input logic [7:0] mask,
                                      input logic [7:0] val);
        return (b & mask) == val;
    endfunction

    // Clear and home are the only slow instructions.
    function automatic logic is_long_cmd(input logic [7:0] b);
        return op_match(b, OP_CLEAR_MASK, OP_CLEAR_VAL) | op_match(b, OP_HOME_MASK, OP_HOME_VAL);
    endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// rtl/lcd_busy_timer.sv - loadable busy down-counter with busy flag
// Ports: clk, nrst (async active-low), load/load_val start a busy period, busy = counter nonzero.
module lcd_busy_timer
    import lcd_4bit_responder_pkg::*;
#(
    parameter int CNT_W = BUSY_CNT_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // The cycle the counter reaches zero already reports not-busy.
    assign busy = (count != '0);

endmodule

// File: rtl/lcd_4bit_responder.sv
// rtl/lcd_4bit_responder.sv - HD44780-style LCD controller model answering a 4/8-bit host bus
// Ports: clk/nrst; host RS, RW, E, DB_in; read-back DB_out/DB_oe; cmd/data event pulses;
//        busy, busy_viol, ddram_addr status; display mode flags.
module lcd_4bit_responder
    import lcd_4bit_responder_pkg::*;
#(
    parameter int BUSY_SHORT = BUSY_SHORT_DEF,
    parameter int BUSY_LONG  = BUSY_LONG_DEF
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            RS,
    input  logic            RW,
    input  logic            E,
    input  logic [3:0]      DB_in,
    output logic [3:0]      DB_out,
    output logic            DB_oe,
    output logic            cmd_valid,
    output logic [7:0]      cmd_byte,
    output logic            data_valid,
    output logic [7:0]      data_byte,
    output logic            busy,
    output logic            busy_viol,
    output logic [AC_W-1:0] ddram_addr,
    output logic            mode_4bit,
    output logic            two_line,
    output logic            disp_on,
    output logic            cursor_on,
    output logic            blink_on,
    output logic            inc_mode,
    output logic            shift_mode
);

    localparam logic [BUSY_CNT_W-1:0] SHORT_V = BUSY_CNT_W'(BUSY_SHORT);
    localparam logic [BUSY_CNT_W-1:0] LONG_V  = BUSY_CNT_W'(BUSY_LONG);

    logic [1:0] e_sync, rs_sync, rw_sync;
    logic [3:0] db_s1, db_s2;
    logic       e_d;
    logic       e_s, rs_s, rw_s;
    logic       strobe, wr_done, accept;
    logic       phase;      // 0 = upper nibble expected next
    logic [3:0] hi_nib;
    logic [7:0] byte_in;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            e_sync  <= '0;
            rs_sync <= '0;
            rw_sync <= '0;
            db_s1   <= '0;
            db_s2   <= '0;
            e_d     <= 1'b0;
        end else begin
            e_sync  <= {e_sync[0], E};
            rs_sync <= {rs_sync[0], RS};
            rw_sync <= {rw_sync[0], RW};
            db_s1   <= DB_in;
            db_s2   <= db_s1;
            e_d     <= e_sync[1];
        end
    end

    assign e_s    = e_sync[1];
    assign rs_s   = rs_sync[1];
    assign rw_s   = rw_sync[1];
    assign strobe = e_d & ~e_s;

    // A write completes a byte on every strobe in 8-bit mode, on the lower nibble in 4-bit mode.
    assign wr_done = strobe & ~rw_s & (~mode_4bit | phase);
    assign accept  = wr_done & ~busy;
    assign byte_in = mode_4bit ? {hi_nib, db_s2} : {db_s2, 4'h0};

    lcd_busy_timer #(.CNT_W(BUSY_CNT_W)) u_busy_timer (
        .clk      (clk),
        .nrst     (nrst),
        .load     (accept),
        .load_val ((!rs_s && is_long_cmd(byte_in)) ? LONG_V : SHORT_V),
        .busy     (busy)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase      <= 1'b0;
            hi_nib     <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            data_valid <= 1'b0;
            data_byte  <= '0;
            busy_viol  <= 1'b0;
            ddram_addr <= '0;
            mode_4bit  <= 1'b0;
            two_line   <= 1'b0;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            inc_mode   <= 1'b0;
            shift_mode <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            data_valid <= 1'b0;
            busy_viol  <= wr_done & busy;

            // Phase follows every 4-bit strobe, including reads and dropped writes.
            if (strobe && mode_4bit) begin
                phase <= ~phase;
                if (!rw_s && !phase) hi_nib <= db_s2;
            end

            if (accept) begin
                if (rs_s) begin
                    data_valid <= 1'b1;
                    data_byte  <= byte_in;
                    ddram_addr <= inc_mode ? ddram_addr + 7'd1 : ddram_addr - 7'd1;
                end else begin
                    cmd_valid <= 1'b1;
                    cmd_byte  <= byte_in;
                    if (op_match(byte_in, OP_CLEAR_MASK, OP_CLEAR_VAL)) begin
                        ddram_addr <= '0;
                        inc_mode   <= 1'b1;
                    end else if (op_match(byte_in, OP_HOME_MASK, OP_HOME_VAL)) begin
                        ddram_addr <= '0;
                    end else if (op_match(byte_in, OP_ENTRY_MASK, OP_ENTRY_VAL)) begin
                        inc_mode   <= byte_in[1];
                        shift_mode <= byte_in[0];
                    end else if (op_match(byte_in, OP_DISP_MASK, OP_DISP_VAL)) begin
                        disp_on   <= byte_in[2];
                        cursor_on <= byte_in[1];
                        blink_on  <= byte_in[0];
                    end else if (op_match(byte_in, OP_SHIFT_MASK, OP_SHIFT_VAL)) begin
                        // Display shifts (S=1) leave the address counter alone.
                        if (!byte_in[3])
                            ddram_addr <= byte_in[2] ? ddram_addr + 7'd1 : ddram_addr - 7'd1;
                    end else if (op_match(byte_in, OP_FUNC_MASK, OP_FUNC_VAL)) begin
                        phase <= 1'b0;
                        // The 8-bit "switch to 4-bit" write carries no valid N bit.
                        if (!mode_4bit && !byte_in[4]) begin
                            mode_4bit <= 1'b1;
                        end else begin
                            two_line  <= byte_in[3];
                            mode_4bit <= ~byte_in[4];
                        end
                    end else if (op_match(byte_in, OP_DDRAM_MASK, OP_DDRAM_VAL)) begin
                        ddram_addr <= byte_in[6:0];
                    end
                end
            end
        end
    end

    assign DB_oe = e_s & rw_s;

    always_comb begin
        DB_out = 4'h0;
        if (DB_oe && !rs_s)
            DB_out = phase ? ddram_addr[3:0] : {busy, ddram_addr[6:4]};
    end

endmodule

// File: tb/tb_lcd_4bit_responder.sv
// tb/tb_lcd_4bit_responder.sv - directed self-checking bench for lcd_4bit_responder
module tb_lcd_4bit_responder;

    localparam int SHORT = 40;
    localparam int LONG  = 100;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       RS = 1'b0, RW = 1'b0, E = 1'b0;
    logic [3:0] DB_in = 4'h0;
    logic [3:0] DB_out;
    logic       DB_oe, cmd_valid, data_valid, busy, busy_viol;
    logic [7:0] cmd_byte, data_byte;
    logic [6:0] ddram_addr;
    logic       mode_4bit, two_line, disp_on, cursor_on, blink_on, inc_mode, shift_mode;

    int n_checks = 0;
    int n_pass   = 0;

    int         cmd_cnt = 0, data_cnt = 0, viol_cnt = 0, busy_cyc = 0;
    logic [7:0] last_cmd = 8'h00, last_data = 8'h00;

    always #5 clk = ~clk;

    lcd_4bit_responder #(.BUSY_SHORT(SHORT), .BUSY_LONG(LONG)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .RS         (RS),
        .RW         (RW),
        .E          (E),
        .DB_in      (DB_in),
        .DB_out     (DB_out),
        .DB_oe      (DB_oe),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .data_valid (data_valid),
        .data_byte  (data_byte),
        .busy       (busy),
        .busy_viol  (busy_viol),
        .ddram_addr (ddram_addr),
        .mode_4bit  (mode_4bit),
        .two_line   (two_line),
        .disp_on    (disp_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .inc_mode   (inc_mode),
        .shift_mode (shift_mode)
    );

    always @(negedge clk) begin
        if (cmd_valid) begin
            cmd_cnt  = cmd_cnt + 1;
            last_cmd = cmd_byte;
        end
        if (data_valid) begin
            data_cnt  = data_cnt + 1;
            last_data = data_byte;
        end
        if (busy_viol) viol_cnt = viol_cnt + 1;
        if (busy) busy_cyc = busy_cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic bus_write(input logic rs, input logic [3:0] nib);
        @(posedge clk); #1;
        RS = rs; RW = 1'b0; DB_in = nib; E = 1'b1;
        repeat (3) @(posedge clk);
        #1 E = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic rs, input logic [7:0] b);
        bus_write(rs, b[7:4]);
        bus_write(rs, b[3:0]);
    endtask

    task automatic bus_read(input logic rs, output logic oe, output logic [3:0] d);
        @(posedge clk); #1;
        RS = rs; RW = 1'b1; E = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        oe = DB_oe;
        d  = DB_out;
        @(posedge clk); #1 E = 1'b0;
        repeat (5) @(posedge clk);
        #1 RW = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'b0, busy}, 32'd0);
    endtask

    logic       oe;
    logic [3:0] d;
    int         snap_busy, snap_cmd, snap_viol, snap_data;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_mode4", {31'b0, mode_4bit}, 0);
        check_val("rst_busy", {31'b0, busy}, 0);
        check_val("rst_ac", {25'b0, ddram_addr}, 0);
        check_val("rst_oe", {31'b0, DB_oe}, 0);
        check_val("rst_cmdv", {31'b0, cmd_valid}, 0);
        #2 nrst = 1'b1;

        // 8-bit wake-up, then switch to 4-bit
        bus_write(0, 4'h3); wait_idle("idle_i1");
        bus_write(0, 4'h3); wait_idle("idle_i2");
        bus_write(0, 4'h3); wait_idle("idle_i3");
        check_val("mode4_after_30", {31'b0, mode_4bit}, 0);
        bus_write(0, 4'h2); wait_idle("idle_i4");
        check_val("mode4_after_20", {31'b0, mode_4bit}, 1);
        check_val("cmd_cnt_init", cmd_cnt, 4);
        check_val("cmd_20", {24'b0, last_cmd}, 32'h20);
        check_val("twoline_20", {31'b0, two_line}, 0);

        write_byte(0, 8'h28); wait_idle("idle_28");
        check_val("cmd_28", {24'b0, last_cmd}, 32'h28);
        check_val("twoline_28", {31'b0, two_line}, 1);
        check_val("mode4_28", {31'b0, mode_4bit}, 1);
        write_byte(0, 8'h06); wait_idle("idle_06");
        check_val("inc_06", {31'b0, inc_mode}, 1);

        // Data write 0x41
        snap_busy = busy_cyc;
        snap_data = data_cnt;
        write_byte(1, 8'h41);
        check_val("data_cnt", data_cnt - snap_data, 1);
        check_val("data_41", {24'b0, last_data}, 32'h41);
        check_val("ac_after_data", {25'b0, ddram_addr}, 1);
        wait_idle("idle_41");
        check_val("busy_short_len", busy_cyc - snap_busy, SHORT);

        // Clear, busy-flag read during busy
        snap_busy = busy_cyc;
        write_byte(0, 8'h01);
        bus_read(0, oe, d);
        check_val("bf_oe", {31'b0, oe}, 1);
        check_val("bf_upper", {28'b0, d}, 32'h8);
        bus_read(0, oe, d);
        check_val("bf_lower", {28'b0, d}, 32'h0);
        check_val("ac_clear", {25'b0, ddram_addr}, 0);
        wait_idle("idle_01");
        check_val("busy_long_len", busy_cyc - snap_busy, LONG);
        check_val("inc_clear", {31'b0, inc_mode}, 1);

        // Write while busy is dropped
        write_byte(0, 8'h07);
        snap_cmd  = cmd_cnt;
        snap_viol = viol_cnt;
        write_byte(0, 8'h0F);
        check_val("viol_pulse", viol_cnt - snap_viol, 1);
        check_val("no_cmd_dropped", cmd_cnt - snap_cmd, 0);
        check_val("disp_unchanged", {31'b0, disp_on}, 0);
        wait_idle("idle_07");
        write_byte(0, 8'h0F); wait_idle("idle_0f");
        check_val("disp_on", {31'b0, disp_on}, 1);
        check_val("cursor_on", {31'b0, cursor_on}, 1);
        check_val("blink_on", {31'b0, blink_on}, 1);
        check_val("shift_07", {31'b0, shift_mode}, 1);

        // Address counter wrap both ways
        write_byte(0, 8'hFF); wait_idle("idle_ff");
        check_val("ac_7f", {25'b0, ddram_addr}, 32'h7F);
        write_byte(1, 8'h55); wait_idle("idle_d1");
        check_val("ac_wrap_up", {25'b0, ddram_addr}, 0);
        write_byte(0, 8'h04); wait_idle("idle_04");
        write_byte(1, 8'h55); wait_idle("idle_d2");
        check_val("ac_wrap_down", {25'b0, ddram_addr}, 32'h7F);
        write_byte(0, 8'h14); wait_idle("idle_14");
        check_val("ac_shift_r", {25'b0, ddram_addr}, 0);
        write_byte(0, 8'h10); wait_idle("idle_10");
        check_val("ac_shift_l", {25'b0, ddram_addr}, 32'h7F);

        // Set DDRAM address and read it back
        write_byte(0, 8'hC0); wait_idle("idle_c0");
        bus_read(0, oe, d);
        check_val("rd_upper_c0", {28'b0, d}, 32'h4);
        bus_read(0, oe, d);
        check_val("rd_lower_c0", {28'b0, d}, 32'h0);
        bus_read(1, oe, d);
        check_val("rd_data_zero", {28'b0, d}, 32'h0);
        check_val("rd_data_oe", {31'b0, oe}, 1);
        bus_read(1, oe, d);

        // Reset between nibbles
        bus_write(0, 4'h8);
        #3 nrst = 1'b0;
        #10;
        check_val("rst2_mode4", {31'b0, mode_4bit}, 0);
        check_val("rst2_ac", {25'b0, ddram_addr}, 0);
        check_val("rst2_busy", {31'b0, busy}, 0);
        check_val("rst2_twoline", {31'b0, two_line}, 0);
        #7 nrst = 1'b1;
        bus_write(0, 4'h2); wait_idle("idle_r1");
        check_val("rst2_mode4_again", {31'b0, mode_4bit}, 1);
        write_byte(0, 8'h85); wait_idle("idle_85");
        check_val("rst2_phase_upper", {25'b0, ddram_addr}, 32'h05);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_4bit_responder.md
LCD_4BIT_RESPONDER -- requirements
Module: lcd_4bit_responder

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset. Ports: clk input 1, rising-edge system clock (100 MHz); nrst input 1, asynchronous active-low reset.
REQ-002 SHALL have these host-side inputs: RS input 1 (register select); RW input 1 (1=read); E input 1 (enable strobe); DB_in input 4 (host DB7..DB4).
REQ-003 SHALL have these bus outputs: DB_out output 4, read data driven to the host; DB_oe output 1, DB_out valid (host must tri-state).
REQ-004 SHALL have these event outputs: cmd_valid output 1, one-cycle pulse; cmd_byte output 8, executed instruction; data_valid output 1, one-cycle pulse; data_byte output 8, written character.
REQ-005 SHALL have these status outputs: busy output 1, busy flag; busy_viol output 1, one-cycle pulse when a write is dropped; ddram_addr output 7, address counter (AC).
REQ-006 SHALL have these mode outputs, 1 bit each: mode_4bit; two_line; disp_on; cursor_on; blink_on; inc_mode; shift_mode.
REQ-007 SHALL have these parameters: BUSY_SHORT, default 4000 (40 us), busy cycles for ordinary instructions and data; BUSY_LONG, default 152000 (1.52 ms), busy cycles for clear and home.

Function
REQ-008 SHALL pass E, RS, RW and DB_in through a 2-flop synchronizer, and SHALL sample RS, RW and DB on the cycle the synchronized E falls (strobe).
REQ-009 8-bit mode (mode_4bit=0): each write strobe SHALL be one instruction, byte={DB_in,4'b0000}.
REQ-010 In 8-bit mode, an instruction with upper nibble 0010 SHALL set mode_4bit=1 and nibble phase=upper. It SHALL NOT change two_line.
REQ-011 4-bit mode: phase SHALL toggle on every strobe, read or write; the upper nibble comes first. Byte assembly SHALL complete on the lower strobe.
REQ-012 Execution latency SHALL be 1 cycle after the completing strobe: cmd_valid or data_valid pulses; busy rises; mode registers update.
REQ-013 Busy counter SHALL load BUSY_SHORT, or BUSY_LONG for 0x01/0x02/0x03. busy=1 while the counter is nonzero; the counter decrements to 0.
REQ-014 A write strobe completing an instruction while busy=1 SHALL be dropped, with busy_viol pulsed. A dropped upper nibble SHALL still toggle phase.
REQ-015 Instruction decode, RS=0:
 - 0x01: AC=0, inc_mode=1.
 - 0x02/0x03: AC=0.
 - 0000_01IS: inc_mode=I, shift_mode=S.
 - 0000_1DCB: disp_on=D, cursor_on=C, blink_on=B.
 - 0001_SR xx: if S=0, AC+1 for R=1 and AC-1 for R=0.
 - 001D_Nxxx: two_line=N, mode_4bit=~D.
 - 01xx_xxxx: accepted, no state.
 - 1AAA_AAAA: AC=AAAAAAA.
REQ-016 Data write (RS=1, RW=0) SHALL present data_byte, then AC+1 if inc_mode else AC-1.
REQ-017 AC arithmetic SHALL be modulo 128: 0x7F+1=0x00 and 0x00-1=0x7F.
REQ-018 Read (RW=1) SHALL drive DB_oe=1 while synchronized E=1. For RS=0, upper phase DB_out={busy,AC[6:4]} and lower phase DB_out=AC[3:0]. For RS=1, DB_out=0000.
REQ-019 Reads SHALL never be dropped and SHALL never affect busy.
REQ-020 When a strobe coincides with the busy counter reaching 0, the strobe SHALL see busy=0.

Reset
REQ-021 nrst low SHALL asynchronously clear every register and output to 0: mode_4bit=0, phase=upper, AC=0, busy=0, DB_oe=0, all pulses 0, synchronizers 0.
REQ-022 Reset mid-byte or mid-busy SHALL discard the partial nibble and the remaining busy time.

Structure
REQ-023 A shared package SHALL hold instruction opcode masks and values, BUSY_SHORT/BUSY_LONG defaults, and AC width (7).
REQ-024 One sub-module, lcd_busy_timer, SHALL implement the loadable down-counter and the busy flag.

Verification
REQ-025 8-bit writes 0x3,0x3,0x3,0x2, then 4-bit 0x2,0x8 -> mode_4bit=1, then cmd_valid with cmd_byte=0x28, two_line=1.
REQ-026 After init, RS=1 nibbles 0x4,0x1 -> data_valid with data_byte=0x41, AC 0->1, busy high exactly BUSY_SHORT cycles.
REQ-027 Command 0x01, then BF read during busy -> upper DB_out=1000, AC=0, busy lasts BUSY_LONG cycles.
REQ-028 Command 0x0F sent during busy -> busy_viol pulse, no cmd_valid, disp_on unchanged; resent after busy -> disp_on=cursor_on=blink_on=1.
REQ-029 Command 0xC0, wait out busy, read -> DB_out upper 0100, lower 0000; then nrst pulse between nibbles -> mode_4bit=0, AC=0, phase=upper.
